// File: rtl/rim_punch.sv
// RIM-format tape punch: dumps a contiguous range of PDP-8 core as leader, address/data
// frame pairs and trailer over a byte-wide valid/ready stream.
module rim_punch #(
  parameter int unsigned LEADER_LEN  = 16,
  parameter int unsigned TRAILER_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] startAddr,
  input  logic [11:0] endAddr,
  output logic [11:0] memAddr,
  output logic        memRead,
  input  logic [11:0] memData,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    StIdle, StLeader, StFetch, StWait, StAddrHi, StAddrLo,
    StDataHi, StDataLo, StStep, StTrailer, StDone
  } state_e;

  localparam logic [15:0] LeadLast  = (LEADER_LEN > 0)  ? 16'(LEADER_LEN - 1)  : 16'd0;
  localparam logic [15:0] TrailLast = (TRAILER_LEN > 0) ? 16'(TRAILER_LEN - 1) : 16'd0;
  localparam logic [7:0]  BlankByte = 8'o200;

  state_e      state_q, state_d;
  logic [11:0] cur_q, cur_d;
  logic [11:0] last_q, last_d;
  logic [11:0] word_q, word_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        xfer;

  // txValid is a pure function of state, so this has no combinational loop.
  assign xfer = txValid & txReady;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cur_q   <= '0;
      last_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    word_d  = word_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_d   = startAddr;
          last_d  = endAddr;
          cnt_d   = '0;
          state_d = (LEADER_LEN == 0) ? StFetch : StLeader;
        end
      end
      StLeader: begin
        if (xfer) begin
          if (cnt_q == LeadLast) state_d = StFetch;
          else cnt_d = cnt_q + 16'd1;
        end
      end
      StFetch: begin
        addr_d  = cur_q;
        state_d = StWait;
      end
      StWait: begin
        word_d  = memData;
        state_d = StAddrHi;
      end
      StAddrHi: if (xfer) state_d = StAddrLo;
      StAddrLo: if (xfer) state_d = StDataHi;
      StDataHi: if (xfer) state_d = StDataLo;
      StDataLo: if (xfer) state_d = StStep;
      StStep: begin
        if (cur_q == last_q) begin
          cnt_d   = '0;
          state_d = (TRAILER_LEN == 0) ? StDone : StTrailer;
        end else begin
          cur_d   = cur_q + 12'd1;
          state_d = StFetch;
        end
      end
      StTrailer: begin
        if (xfer) begin
          if (cnt_q == TrailLast) state_d = StDone;
          else cnt_d = cnt_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    memRead = 1'b0;
    txValid = 1'b0;
    txData  = 8'd0;
    busy    = 1'b1;
    done    = 1'b0;
    // The address stays parked on the last fetched word; memRead alone qualifies it.
    memAddr = (state_q == StFetch) ? cur_q : addr_q;
    unique case (state_q)
      StIdle:    busy = 1'b0;
      StLeader:  begin txValid = 1'b1; txData = BlankByte; end
      StFetch:   memRead = 1'b1;
      StWait:    ;
      StAddrHi:  begin txValid = 1'b1; txData = {2'b01, cur_q[11:6]}; end
      StAddrLo:  begin txValid = 1'b1; txData = {2'b00, cur_q[5:0]}; end
      StDataHi:  begin txValid = 1'b1; txData = {2'b00, word_q[11:6]}; end
      StDataLo:  begin txValid = 1'b1; txData = {2'b00, word_q[5:0]}; end
      StStep:    ;
      StTrailer: begin txValid = 1'b1; txData = BlankByte; end
      StDone:    begin busy = 1'b0; done = 1'b1; end
      default:   busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rim_punch.sv
// Bench for rim_punch: two instances (2/2 leader/trailer and 0/0), memory model,
// byte-stream reference built from the RIM frame rules.
module tb_rim_punch;

  typedef logic [7:0]  bq_t[$];
  typedef logic [11:0] aq_t[$];

  typedef struct {
    logic [11:0] s;
    logic [11:0] e;
    int          words;
    logic [7:0]  addr_hi;
    logic [7:0]  addr_lo;
    logic        rnd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [11:0] mem [4096];

  // Instance A: LEADER_LEN=2, TRAILER_LEN=2
  logic        rst_n_a, start_a, mem_read_a, tx_valid_a, tx_ready_a, busy_a, done_a;
  logic [11:0] sa_a, ea_a, mem_addr_a, mem_data_a;
  logic [7:0]  tx_data_a;
  // Instance B: no leader, no trailer
  logic        rst_n_b, start_b, mem_read_b, tx_valid_b, tx_ready_b, busy_b, done_b;
  logic [11:0] sa_b, ea_b, mem_addr_b, mem_data_b;
  logic [7:0]  tx_data_b;

  rim_punch #(.LEADER_LEN(2), .TRAILER_LEN(2)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .startAddr(sa_a), .endAddr(ea_a),
    .memAddr(mem_addr_a), .memRead(mem_read_a), .memData(mem_data_a),
    .txData(tx_data_a), .txValid(tx_valid_a), .txReady(tx_ready_a),
    .busy(busy_a), .done(done_a)
  );

  rim_punch #(.LEADER_LEN(0), .TRAILER_LEN(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .startAddr(sa_b), .endAddr(ea_b),
    .memAddr(mem_addr_b), .memRead(mem_read_b), .memData(mem_data_b),
    .txData(tx_data_b), .txValid(tx_valid_b), .txReady(tx_ready_b),
    .busy(busy_b), .done(done_b)
  );

  // Memory returns data one cycle after memRead; garbage otherwise.
  always @(posedge clk) begin
    mem_data_a <= mem_read_a ? mem[mem_addr_a] : 12'($urandom);
    mem_data_b <= mem_read_b ? mem[mem_addr_b] : 12'($urandom);
  end

  logic hold_a = 1'b0;
  logic rnd_a  = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_ready_a = hold_a ? 1'b0 : (rnd_a ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  bq_t  got_a, got_b, exp_q;
  aq_t  rd_a, rd_b, exp_rd;
  int   dones_a = 0, dones_b = 0, bytes_at_done_b = 0;
  logic stall_a = 1'b0;
  logic [7:0] stall_data_a;

  always @(negedge clk) begin
    if (!rst_n_a) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        checks++;
        if (!(tx_valid_a === 1'b1 && tx_data_a === stall_data_a)) begin
          failures++;
          $display("FAIL stall_hold: valid=%b data=%o required valid=1 data=%o",
                   tx_valid_a, tx_data_a, stall_data_a);
        end
      end
      stall_a      = tx_valid_a && !tx_ready_a;
      stall_data_a = tx_data_a;
      if (tx_valid_a && tx_ready_a) got_a.push_back(tx_data_a);
      if (mem_read_a) rd_a.push_back(mem_addr_a);
      if (done_a) dones_a++;
    end
    if (rst_n_b) begin
      if (tx_valid_b && tx_ready_b) got_b.push_back(tx_data_b);
      if (mem_read_b) rd_b.push_back(mem_addr_b);
      if (done_b) begin
        dones_b++;
        bytes_at_done_b = got_b.size();
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0o required %0o", name, act, exp);
    end
  endtask

  // Reference: leader, then per word {0100|addr hi, addr lo, data hi, data lo}, then trailer.
  function automatic void model(input logic [11:0] s, input logic [11:0] e,
                                input int lead, input int trail);
    int n;
    logic [11:0] a, w;
    exp_q.delete();
    exp_rd.delete();
    n = int'(12'(e - s)) + 1;
    repeat (lead) exp_q.push_back(8'o200);
    for (int k = 0; k < n; k++) begin
      a = s + 12'(k);
      w = mem[a];
      exp_rd.push_back(a);
      exp_q.push_back(8'o100 + 8'(a / 64));
      exp_q.push_back(8'(a % 64));
      exp_q.push_back(8'(w / 64));
      exp_q.push_back(8'(w % 64));
    end
    repeat (trail) exp_q.push_back(8'o200);
  endfunction

  function automatic void cmp_bytes(input string name, input bq_t got, input bq_t exp);
    int bad = -1;
    checks++;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    if (bad < 0 && got.size() != exp.size()) bad = (got.size() < exp.size()) ? got.size()
                                                                              : exp.size();
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: stream differs at byte %0d (got %0d bytes, required %0d; got %o required %o)",
               name, bad, got.size(), exp.size(),
               (bad < got.size()) ? got[bad] : 8'hff, (bad < exp.size()) ? exp[bad] : 8'hff);
    end
  endfunction

  function automatic void cmp_addrs(input string name, input aq_t got, input aq_t exp);
    int bad = -1;
    checks++;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    if (bad < 0 && got.size() != exp.size()) bad = 0;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: read addresses differ at %0d (got %0d reads, required %0d)",
               name, bad, got.size(), exp.size());
    end
  endfunction

  task automatic go_a(input logic [11:0] s, input logic [11:0] e);
    got_a.delete();
    rd_a.delete();
    dones_a = 0;
    @(posedge clk); #1;
    start_a = 1'b1; sa_a = s; ea_a = e;
    @(posedge clk); #1;
    start_a = 1'b0; sa_a = 12'($urandom); ea_a = 12'($urandom);
  endtask

  task automatic wait_done_a(input string name, input int budget);
    int n = 0;
    while (dones_a == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, " done_seen"}, 32'(dones_a != 0), 32'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_bytes_a(input int cnt);
    int n = 0;
    while (got_a.size() < cnt && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("wait_bytes", 32'(got_a.size()), 32'(cnt));
  endtask

  task automatic finish_a(input string name, input logic [11:0] s, input logic [11:0] e);
    model(s, e, 2, 2);
    cmp_bytes({name, " stream"}, got_a, exp_q);
    cmp_addrs({name, " reads"}, rd_a, exp_rd);
    check({name, " done_count"}, 32'(dones_a), 32'd1);
  endtask

  vec_t vecs[5];
  logic [7:0] plan1[8];
  logic [7:0] plan2[8];

  initial begin
    logic [11:0] rs, re;
    int n;
    vecs[0] = '{12'o0200, 12'o0200, 1, 8'o102, 8'o000, 1'b0};
    vecs[1] = '{12'o7777, 12'o0000, 2, 8'o177, 8'o077, 1'b0};
    vecs[2] = '{12'o7775, 12'o0002, 6, 8'o177, 8'o075, 1'b1};
    vecs[3] = '{12'o0100, 12'o0107, 8, 8'o101, 8'o000, 1'b1};
    vecs[4] = '{12'o4321, 12'o4321, 1, 8'o143, 8'o021, 1'b1};
    plan1 = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o012, 8'o034, 8'o200, 8'o200};
    plan2 = '{8'o177, 8'o077, 8'o070, 8'o070, 8'o100, 8'o000, 8'o000, 8'o001};

    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    mem[12'o0200] = 12'o1234;
    mem[12'o7777] = 12'o7070;
    mem[12'o0000] = 12'o0001;

    rst_n_a = 1'b0; start_a = 1'b0; sa_a = '0; ea_a = '0;
    rst_n_b = 1'b0; start_b = 1'b0; sa_b = '0; ea_b = '0; tx_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst memAddr", 32'(mem_addr_a), 32'd0);
    check("rst memRead", 32'(mem_read_a), 32'd0);
    check("rst txData", 32'(tx_data_a), 32'd0);
    check("rst txValid", 32'(tx_valid_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Table-driven ranges
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      rnd_a = vecs[v].rnd;
      go_a(vecs[v].s, vecs[v].e);
      wait_done_a("vec", 2000);
      finish_a("vec", vecs[v].s, vecs[v].e);
      check("vec words", 32'(rd_a.size()), 32'(vecs[v].words));
      check("vec addr_hi", 32'((got_a.size() > 3) ? got_a[2] : 8'hff), 32'(vecs[v].addr_hi));
      check("vec addr_lo", 32'((got_a.size() > 3) ? got_a[3] : 8'hff), 32'(vecs[v].addr_lo));
      if (v == 0) begin
        for (int i = 0; i < 8; i++)
          check("plan single_word", 32'((i < got_a.size()) ? got_a[i] : 8'hff), 32'(plan1[i]));
        check("plan single_word read_addr", 32'((rd_a.size() > 0) ? rd_a[0] : 12'hfff),
              32'(12'o0200));
      end
      if (v == 1) begin
        for (int i = 0; i < 8; i++)
          check("plan wrap", 32'((i + 2 < got_a.size()) ? got_a[i + 2] : 8'hff), 32'(plan2[i]));
      end
    end

    // Backpressure during DATA_HI
    @(negedge clk);
    rnd_a = 1'b0;
    go_a(12'o0200, 12'o0201);
    wait_bytes_a(4);
    hold_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("bp valid", 32'(tx_valid_a), 32'd1);
      check("bp data", 32'(tx_data_a), 32'({2'b00, mem[12'o0200][11:6]}));
    end
    hold_a = 1'b0;
    wait_done_a("bp", 2000);
    finish_a("bp", 12'o0200, 12'o0201);

    // Reset during ADDR_LO, then a fresh dump
    go_a(12'o0300, 12'o0301);
    wait_bytes_a(3);
    @(posedge clk); #1;
    rst_n_a = 1'b0;
    @(posedge clk); #1;
    rst_n_a = 1'b1;
    check("rst_mid txValid", 32'(tx_valid_a), 32'd0);
    check("rst_mid busy", 32'(busy_a), 32'd0);
    check("rst_mid memRead", 32'(mem_read_a), 32'd0);
    check("rst_mid done", 32'(done_a), 32'd0);
    repeat (3) @(negedge clk);
    go_a(12'o0400, 12'o0400);
    wait_done_a("restart", 2000);
    finish_a("restart", 12'o0400, 12'o0400);

    // Start pulses while busy and in the DONE cycle are ignored
    rnd_a = 1'b1;
    go_a(12'o0500, 12'o0502);
    n = 0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (done_a) begin
        start_a = 1'b1; sa_a = 12'o0000; ea_a = 12'o7777;
        break;
      end
      start_a = busy_a && ($urandom_range(0, 2) == 0);
      sa_a = 12'($urandom); ea_a = 12'($urandom);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("ignore busy_after", 32'(busy_a), 32'd0);
    finish_a("ignore", 12'o0500, 12'o0502);

    // Random short ranges, including wrap-around, random backpressure
    for (int r = 0; r < 8; r++) begin
      rs = 12'($urandom);
      re = rs + 12'($urandom_range(0, 4));
      go_a(rs, re);
      wait_done_a("rand", 4000);
      finish_a("rand", rs, re);
    end
    rnd_a = 1'b0;

    // Full-core dump on the instance without leader/trailer
    got_b.delete();
    rd_b.delete();
    @(posedge clk); #1;
    start_b = 1'b1; sa_b = 12'o0000; ea_b = 12'o7777;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    while (dones_b == 0 && n < 40000) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (3) @(negedge clk);
    model(12'o0000, 12'o7777, 0, 0);
    check("full first_byte", 32'((got_b.size() > 0) ? got_b[0] : 8'hff), 32'(8'o100));
    check("full byte_count", 32'(got_b.size()), 32'd16384);
    check("full read_count", 32'(rd_b.size()), 32'd4096);
    check("full done_count", 32'(dones_b), 32'd1);
    check("full bytes_before_done", 32'(bytes_at_done_b), 32'd16384);
    cmp_bytes("full stream", got_b, exp_q);
    cmp_addrs("full reads", rd_b, exp_rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
